// File: rtl/pwm_comparador_multi.sv
// pwm_comparador_multi: multi-channel carrier-vs-reference PWM with double-buffered references
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       1 = carrier runs; 0 = carrier held at 0, outputs low, references follow shadow
//   mode         carrier shape request (0 saw, 1 triangle), applied at period boundaries
//   ref_in       packed references, channel k at [k*WIDTH +: WIDTH]
//   ref_valid    loads ref_in into the shadow registers
//   pwm_out      registered PWM, one bit per channel
//   carrier      current carrier value
//   period_start one-cycle pulse when the carrier is written to 0 from a nonzero value
module pwm_comparador_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] ref_in,
    input  logic                      ref_valid,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [WIDTH-1:0]          carrier,
    output logic                      period_start
);
    localparam int              CW      = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   PS_LAST = CW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX    = '1;

    logic [CW-1:0]             ps_cnt;
    logic                      dir_down, act_mode, tick, boundary, next_down;
    logic [WIDTH-1:0]          next_car;
    logic [CHANNELS*WIDTH-1:0] shadow_ref, active_ref;
    logic [CHANNELS-1:0]       cmp;

    assign tick = enable && ps_cnt == PS_LAST;

    // Sawtooth never turns around, so its direction stays up; a mode switch at a
    // boundary therefore always starts the new shape counting up from 0.
    always_comb begin
        next_car  = (act_mode && dir_down) ? carrier - 1'b1 : carrier + 1'b1;
        next_down = act_mode && (dir_down ? next_car != '0 : next_car == MAX);
        boundary  = tick && next_car == '0 && carrier != '0;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_cmp
        assign cmp[k] = active_ref[k*WIDTH +: WIDTH] >= carrier;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt       <= '0;
            carrier      <= '0;
            dir_down     <= 1'b0;
            act_mode     <= 1'b0;
            shadow_ref   <= '0;
            active_ref   <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            if (ref_valid)
                shadow_ref <= ref_in;
            if (!enable) begin
                ps_cnt       <= '0;
                carrier      <= '0;
                dir_down     <= 1'b0;
                pwm_out      <= '0;
                period_start <= 1'b0;
                // Keep tracking the shadow so the first period after enable is current.
                active_ref   <= shadow_ref;
                act_mode     <= mode;
            end else begin
                ps_cnt       <= tick ? '0 : ps_cnt + 1'b1;
                period_start <= boundary;
                pwm_out      <= cmp;
                if (tick) begin
                    carrier  <= next_car;
                    dir_down <= next_down;
                end
                // Old shadow wins if ref_valid lands on the boundary edge.
                if (boundary) begin
                    active_ref <= shadow_ref;
                    act_mode   <= mode;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_comparador_multi.sv
// tb_pwm_comparador_multi: scoreboard bench for pwm_comparador_multi (WIDTH=4, CHANNELS=2)
module tb_pwm_comparador_multi;
    logic       clk = 0, rst_n = 0, enable = 0, mode = 0, ref_valid = 0;
    logic [7:0] ref_in = 0;
    logic [1:0] pwm_out;
    logic [3:0] carrier;
    logic       period_start;
    logic       enable3 = 0, mode3 = 0, ref_valid3 = 0;
    logic [7:0] ref_in3 = 0;
    logic [1:0] pwm3;
    logic [3:0] car3;
    logic       ps3;
    logic       probe = 0;
    int         ncyc = 0, vectors = 0, miscompares = 0;

    typedef struct {
        int         cyc;
        int         dut;
        int         tst;
        int         k;
        logic [3:0] car;
        logic [1:0] pwm;
        logic       ps;
    } exp_t;
    exp_t q[$];

    pwm_comparador_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .ref_in(ref_in),
        .ref_valid(ref_valid), .pwm_out(pwm_out), .carrier(carrier), .period_start(period_start)
    );

    pwm_comparador_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable3), .mode(mode3), .ref_in(ref_in3),
        .ref_valid(ref_valid3), .pwm_out(pwm3), .carrier(car3), .period_start(ps3)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    function automatic int tri_w(input int n);
        int t;
        t = n % 30;
        return t <= 15 ? t : 30 - t;
    endfunction

    function automatic int f4(input int n);
        return n <= 16 ? n % 16 : tri_w(n - 16);
    endfunction

    task automatic drive(input logic en, input logic md, input logic [7:0] rin, input logic rv);
        @(negedge clk);
        enable = en; mode = md; ref_in = rin; ref_valid = rv;
    endtask

    task automatic drive3(input logic en, input logic [7:0] rin, input logic rv);
        @(negedge clk);
        enable3 = en; ref_in3 = rin; ref_valid3 = rv;
    endtask

    task automatic ex(input int d, input int t, input int k, input int c, input int p1,
                      input int p0, input int s, input bit now = 0);
        exp_t e;
        e.cyc = now ? ncyc : ncyc + 1;
        e.dut = d; e.tst = t; e.k = k;
        e.car = 4'(c); e.pwm = {1'(p1), 1'(p0)}; e.ps = 1'(s);
        q.push_back(e);
    endtask

    task automatic pulse_probe;
        probe = 1; #1; probe = 0;
    endtask

    // Monitor: checks every entry due by the current cycle, 1 time unit after the edge.
    initial begin
        exp_t       e;
        logic [3:0] ac;
        logic [1:0] ap;
        logic       as;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            while (q.size() > 0 && q[0].cyc <= ncyc) begin
                e  = q.pop_front();
                ac = e.dut != 0 ? car3 : carrier;
                ap = e.dut != 0 ? pwm3 : pwm_out;
                as = e.dut != 0 ? ps3 : period_start;
                vectors++;
                if ({ac, ap, as} !== {e.car, e.pwm, e.ps}) begin
                    miscompares++;
                    $display("FAIL t%0d k%0d dut%0d: got car=%0d pwm=%b ps=%b, want car=%0d pwm=%b ps=%b",
                             e.tst, e.k, e.dut, ac, ap, as, e.car, e.pwm, e.ps);
                end
            end
        end
    end

    initial begin
        int c, a;
        #3;
        ex(0, 0, 0, 0, 0, 0, 0, 1); ex(1, 0, 0, 0, 0, 0, 0, 1); pulse_probe();
        @(negedge clk); rst_n = 1;
        // 1: sawtooth, ch0=8 ch1=3 loaded while disabled
        drive(0, 0, 8'h38, 1); ex(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 8'h38, 0); ex(0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            drive(1, 0, 8'h38, 0);
            c = (k - 1) % 16;
            ex(0, 1, k, k % 16, c <= 3, c <= 8, k % 16 == 0);
        end
        // 2: triangle, ch0=15 ch1=0
        drive(0, 1, 8'h0F, 1); ex(0, 2, 0, 0, 0, 0, 0);
        drive(0, 1, 8'h0F, 0); ex(0, 2, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 65; k++) begin
            drive(1, 1, 8'h0F, 0);
            c = tri_w(k - 1);
            ex(0, 2, k, tri_w(k), c == 0, 1, k % 30 == 0);
        end
        // 3: ch0 12 -> 4 mid-period, then 9 on the boundary edge
        drive(0, 0, 8'hCC, 1); ex(0, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 8'hCC, 0); ex(0, 3, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            drive(1, 0, k == 5 ? 8'hC4 : k == 32 ? 8'hC9 : 8'hCC, k == 5 || k == 32);
            a = k <= 16 ? 12 : k <= 48 ? 4 : 9;
            c = (k - 1) % 16;
            ex(0, 3, k, k % 16, c <= 12, c <= a, k % 16 == 0);
        end
        // 4: mode saw->tri at carrier 7, disable at carrier 9
        drive(0, 0, 8'h38, 1); ex(0, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 8'h38, 0); ex(0, 4, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 25; k++) begin
            drive(1, k >= 8, 8'h38, 0);
            c = f4(k - 1);
            ex(0, 4, k, f4(k), c <= 3, c <= 8, k == 16);
        end
        for (int k = 26; k <= 27; k++) begin
            drive(0, 1, 8'h38, 0); ex(0, 4, k, 0, 0, 0, 0);
        end
        // 5: asynchronous reset mid-period, restart from power-up state
        drive(0, 0, 8'h38, 0); ex(0, 5, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(1, 0, 8'h38, 0);
            c = k - 1;
            ex(0, 5, k, k, c <= 3, c <= 8, 0);
        end
        @(posedge clk); #3;
        rst_n = 0;
        ex(0, 5, 99, 0, 0, 0, 0, 1); ex(1, 5, 99, 0, 0, 0, 0, 1); pulse_probe();
        for (int k = 1; k <= 2; k++) begin
            drive(1, 0, 8'h38, 0); ex(0, 5, 100 + k, 0, 0, 0, 0);
        end
        for (int k = 1; k <= 20; k++) begin
            drive(1, 0, 8'h38, 0);
            if (k == 1) rst_n = 1;
            c = (k - 1) % 16;
            ex(0, 5, k, k % 16, c == 0, c == 0, k == 16);
        end
        // 6: PRESCALE=3 sawtooth, ch0=5 ch1=15
        drive3(0, 8'hF5, 1); ex(1, 6, 0, 0, 0, 0, 0);
        drive3(0, 8'hF5, 0); ex(1, 6, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            drive3(1, 8'hF5, 0);
            c = ((k - 1) / 3) % 16;
            ex(1, 6, k, (k / 3) % 16, 1, c <= 5, k % 48 == 0);
        end
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pwm_comparador_multi.md
Name: pwm_comparador_multi

Overview:
- Parametrised successor to the single-channel sine-vs-sawtooth comparator.
- Generates one internal carrier, either sawtooth or triangle, with a programmable prescaler.
- Compares the carrier against CHANNELS reference samples, which come from the sine LUT or the ADC/UART path, and drives one PWM output per channel.
- References are double-buffered (shadow, then active) and update only at period boundaries, so no output glitches mid-period.

Parameters:
WIDTH, 8, bit width of the carrier and of each reference sample.
CHANNELS, 2, number of independent reference/PWM channels.
PRESCALE, 1, clk cycles per carrier step (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  1 = carrier runs; 0 = carrier held, outputs forced low.
mode  input  1  carrier shape request: 0 = sawtooth, 1 = triangle.
ref_in  input  CHANNELS*WIDTH  packed references; channel k is bits [k*WIDTH +: WIDTH].
ref_valid  input  1  strobe; latches ref_in into the shadow registers.
pwm_out  output  CHANNELS  registered PWM, one bit per channel.
carrier  output  WIDTH  current carrier value, for debug and for the ADC sample trigger.
period_start  output  1  one-cycle pulse on the edge where the carrier becomes 0 (new period).

Behaviour:
- Reset (rst_n low, asynchronous):
  - carrier=0, direction=up, prescale counter=0, active mode=saw.
  - shadow and active refs = 0.
  - pwm_out=0, period_start=0.
- Step tick: asserted when enable=1 and prescale counter == PRESCALE-1. The counter then wraps to 0; otherwise it increments.
- Sawtooth: on each tick the carrier increments. MAX = 2^WIDTH-1 wraps to 0. Period = 2^WIDTH ticks.
- Triangle:
  - up: +1 per tick; on reaching MAX, direction becomes down.
  - down: -1 per tick; on reaching 0, direction becomes up.
  - Sequence 0,1..MAX,MAX-1..1,0; period = 2*MAX ticks.
  - MAX and 0 each occur once per period.
- Period boundary: the tick edge where the carrier is written to 0 from a nonzero value. On that edge:
  - period_start <= 1 for one cycle;
  - active refs <= shadow refs;
  - active mode <= mode.
  - mode changes mid-period take effect only at the boundary.
- ref_valid: shadow <= ref_in on the same edge.
  - If ref_valid coincides with a boundary, active takes the OLD shadow; the new value applies from the following period.
- Compare: pwm_out[k] <= (active_ref[k] >= carrier), evaluated every cycle while enabled. Equivalent to the legacy rule "carrier > ref gives 0, else 1".
  - Latency: 1 clk from carrier/ref to pwm_out.
  - ref=MAX gives a constant 1.
  - ref=0 gives 1 only while carrier==0.
- enable=0 (synchronous):
  - carrier <= 0, direction <= up, prescale counter <= 0.
  - pwm_out <= 0, period_start <= 0.
  - active refs <= shadow refs and active mode <= mode every cycle, so the first period after enable uses current values.
  - No period_start pulse on the enable edge.
- Re-enable: the first carrier step occurs PRESCALE cycles after enable goes high.
- All arithmetic is unsigned WIDTH-bit. No saturation is needed because turnaround is explicit.
- Reset mid-period: everything returns to reset values immediately. After release, operation resumes as from power-up.

Test Plan:
- WIDTH=4, PRESCALE=1, saw, enable=1, ref=8 on ch0 (loaded while disabled):
  - carrier 0..15 repeats; period_start every 16 cycles;
  - pwm_out[0]=1 for 9 of every 16 cycles (carrier 0..8), delayed 1 clk.
- WIDTH=4, triangle, ref ch0=15, ch1=0:
  - period 30 cycles; pwm_out[0] constant 1;
  - pwm_out[1] high exactly 1 cycle per period, following carrier==0.
- Mid-period ref_valid with ref=4 while active=12:
  - pwm duty unchanged until next period_start, then high while carrier<=4.
  - Repeat with ref_valid on the boundary cycle: change delayed one further period.
- PRESCALE=3, saw, WIDTH=4:
  - carrier advances every 3rd clk;
  - after enable rises, the first increment appears on the 3rd edge; period = 48 clk.
- mode toggled saw->triangle at carrier=7: sawtooth continues to 15, wraps to 0, then the triangle begins. Drop enable at carrier=9: next cycle carrier=0, pwm_out=0.
- Assert rst_n low asynchronously mid-cycle: outputs clear without waiting for clk. After release with enable=1, the sequence restarts from carrier 0.
